// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, typedefs and constants for the regfile_sb register file.
// Optional feature macro used by regfile_sb: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

    localparam int unsigned REGFILE_DWIDTH = 32;
    localparam int unsigned REGFILE_NREGS  = 32;
    localparam int unsigned REGFILE_NRD    = 2;

    // Index of the architectural zero register.
    localparam int unsigned ZERO_IDX = 0;

    typedef logic [$clog2(REGFILE_NREGS)-1:0] addr_t;
    typedef logic [REGFILE_DWIDTH-1:0]        data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy bit per register, set-over-clear priority and the sticky
// writeback-protocol error flag. Callers pre-qualify set/clear (e.g. the zero register).
module regfile_scoreboard #(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned AWIDTH = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en_i,
    input  logic [AWIDTH-1:0] set_idx_i,
    input  logic              clr_en_i,
    input  logic [AWIDTH-1:0] clr_idx_i,
    output logic [NREGS-1:0]  busy_vec_o,
    output logic              wb_err_o
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [NREGS-1:0] set_vec, clr_vec;
    logic             wb_err_q, wb_err_d;

    // Next busy state: clear from writeback, then set from issue so a same-cycle set wins.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en_i) set_vec[set_idx_i] = 1'b1;
        if (clr_en_i) clr_vec[clr_idx_i] = 1'b1;
        busy_d   = (busy_q & ~clr_vec) | set_vec;
        // A writeback to a register nobody reserved is a protocol error; it latches.
        wb_err_d = wb_err_q | (clr_en_i & ~busy_q[clr_idx_i]);
    end

    // Scoreboard state, dropped at once on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q   <= '0;
            wb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign busy_vec_o = busy_q;
    assign wb_err_o   = wb_err_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port architectural register file with issue scoreboard and stall logic.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data/busy release to readers.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DWIDTH   = REGFILE_DWIDTH,
    parameter int unsigned NREGS    = REGFILE_NREGS,
    parameter int unsigned NRD      = REGFILE_NRD,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AWIDTH  = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AWIDTH-1:0] rs_addr_i,
    input  logic [NRD-1:0]        rs_en_i,
    output logic [NRD*DWIDTH-1:0] rs_data_o,
    output logic [NRD-1:0]        rs_busy_o,
    input  logic                  issue_valid_i,
    input  logic                  issue_wr_i,
    input  logic [AWIDTH-1:0]     issue_rd_i,
    output logic                  issue_stall_o,
    input  logic                  wb_valid_i,
    input  logic [AWIDTH-1:0]     wb_rd_i,
    input  logic [DWIDTH-1:0]     wb_data_i,
    output logic [NREGS-1:0]      busy_vec_o,
    output logic                  wb_err_o
);

    logic [DWIDTH-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_vec;
    logic [NRD-1:0]    rs_busy;
    logic              dst_busy;
    logic              wb_we;
    logic              issue_set;
    logic              issue_rd_zero;

    // Writes to a hardwired zero register neither store, clear busy, nor flag errors.
    assign wb_we         = wb_valid_i & ~((ZERO_REG != 0) && (wb_rd_i == AWIDTH'(ZERO_IDX)));
    assign issue_rd_zero = (ZERO_REG != 0) && (issue_rd_i == AWIDTH'(ZERO_IDX));
    assign issue_set     = issue_valid_i & ~issue_stall_o & issue_wr_i & ~issue_rd_zero;

    // Data array: every register cleared on reset, one write port from writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wb_we) begin
            regs_q[wb_rd_i] <= wb_data_i;
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .AWIDTH (AWIDTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (issue_set),
        .set_idx_i  (issue_rd_i),
        .clr_en_i   (wb_we),
        .clr_idx_i  (wb_rd_i),
        .busy_vec_o (busy_vec),
        .wb_err_o   (wb_err_o)
    );

    // Read muxes and destination busy lookup, with optional writeback forwarding.
    always_comb begin
        logic [AWIDTH-1:0] addr;
        rs_data_o = '0;
        rs_busy   = '0;
        addr      = '0;
        for (int p = 0; p < NRD; p++) begin
            addr = rs_addr_i[p*AWIDTH +: AWIDTH];
            if ((ZERO_REG != 0) && (addr == AWIDTH'(ZERO_IDX))) begin
                rs_data_o[p*DWIDTH +: DWIDTH] = '0;
                rs_busy[p]                    = 1'b0;
            end else begin
                rs_data_o[p*DWIDTH +: DWIDTH] = regs_q[addr];
                rs_busy[p]                    = busy_vec[addr];
`ifdef REGFILE_BYPASS_EN
                if (wb_we && (wb_rd_i == addr)) begin
                    rs_data_o[p*DWIDTH +: DWIDTH] = wb_data_i;
                    rs_busy[p]                    = 1'b0;
                end
`endif
            end
        end
        dst_busy = issue_rd_zero ? 1'b0 : busy_vec[issue_rd_i];
`ifdef REGFILE_BYPASS_EN
        if (wb_we && (wb_rd_i == issue_rd_i)) dst_busy = 1'b0;
`endif
    end

    assign rs_busy_o     = rs_busy;
    assign issue_stall_o = issue_valid_i & ((|(rs_en_i & rs_busy)) | (issue_wr_i & dst_busy));
    assign busy_vec_o    = busy_vec;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed, table-driven self-checking bench for regfile_sb (default params).
module tb_regfile_sb;

    localparam int unsigned DW  = 32;
    localparam int unsigned NR  = 32;
    localparam int unsigned NP  = 2;
    localparam int unsigned AW  = 5;

    logic              clk;
    logic              rst;
    logic [NP*AW-1:0]  rs_addr_i;
    logic [NP-1:0]     rs_en_i;
    logic [NP*DW-1:0]  rs_data_o;
    logic [NP-1:0]     rs_busy_o;
    logic              issue_valid_i;
    logic              issue_wr_i;
    logic [AW-1:0]     issue_rd_i;
    logic              issue_stall_o;
    logic              wb_valid_i;
    logic [AW-1:0]     wb_rd_i;
    logic [DW-1:0]     wb_data_i;
    logic [NR-1:0]     busy_vec_o;
    logic              wb_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_sb dut (
        .clk           (clk),
        .rst           (rst),
        .rs_addr_i     (rs_addr_i),
        .rs_en_i       (rs_en_i),
        .rs_data_o     (rs_data_o),
        .rs_busy_o     (rs_busy_o),
        .issue_valid_i (issue_valid_i),
        .issue_wr_i    (issue_wr_i),
        .issue_rd_i    (issue_rd_i),
        .issue_stall_o (issue_stall_o),
        .wb_valid_i    (wb_valid_i),
        .wb_rd_i       (wb_rd_i),
        .wb_data_i     (wb_data_i),
        .busy_vec_o    (busy_vec_o),
        .wb_err_o      (wb_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic [AW-1:0] addr1;
        logic [DW-1:0] exp0;
        logic [DW-1:0] exp1;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rdata(input int p);
        return rs_data_o[p*DW +: DW];
    endfunction

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rs_addr_i = {a1, a0};
    endtask

    task automatic idle();
        issue_valid_i = 1'b0;
        issue_wr_i    = 1'b0;
        issue_rd_i    = '0;
        wb_valid_i    = 1'b0;
        wb_rd_i       = '0;
        wb_data_i     = '0;
        rs_en_i       = '0;
    endtask

    initial begin
        vecs[0] = '{rd: 5'd1,  data: 32'h0000_0001, addr1: 5'd5,  exp0: 32'h0000_0001,
                    exp1: 32'hDEAD_BEEF};
        vecs[1] = '{rd: 5'd31, data: 32'hFFFF_FFFF, addr1: 5'd1,  exp0: 32'hFFFF_FFFF,
                    exp1: 32'h0000_0001};
        vecs[2] = '{rd: 5'd0,  data: 32'h0000_ABCD, addr1: 5'd31, exp0: 32'h0,
                    exp1: 32'hFFFF_FFFF};
        vecs[3] = '{rd: 5'd12, data: 32'h1234_5678, addr1: 5'd0,  exp0: 32'h1234_5678,
                    exp1: 32'h0};
        vecs[4] = '{rd: 5'd5,  data: 32'h0BAD_F00D, addr1: 5'd31, exp0: 32'h0BAD_F00D,
                    exp1: 32'hFFFF_FFFF};
        vecs[5] = '{rd: 5'd16, data: 32'hA5A5_A5A5, addr1: 5'd5,  exp0: 32'hA5A5_A5A5,
                    exp1: 32'h0BAD_F00D};

        rst = 1'b0;
        idle();
        set_rd(5'd0, 5'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Reset state: every register reads zero on both ports, nothing busy, no stall.
        chk("reset_busy_vec", 64'(busy_vec_o), 64'h0);
        chk("reset_err", 64'(wb_err_o), 64'h0);
        for (int a = 0; a < NR; a++) begin
            set_rd(AW'(a), AW'(NR - 1 - a));
            issue_valid_i = 1'b1;
            rs_en_i       = 2'b11;
            #1;
            chk($sformatf("reset_rd0_x%0d", a), 64'(rdata(0)), 64'h0);
            chk($sformatf("reset_rd1_x%0d", NR - 1 - a), 64'(rdata(1)), 64'h0);
            chk($sformatf("reset_stall_%0d", a), 64'(issue_stall_o), 64'h0);
        end
        idle();
        tick();

        // RAW: reserve x5, dependent issue stalls until writeback.
        issue_valid_i = 1'b1; issue_wr_i = 1'b1; issue_rd_i = 5'd5;
        #1;
        chk("raw_first_issue_stall", 64'(issue_stall_o), 64'h0);
        tick();
        chk("raw_busy_set", 64'(busy_vec_o), 64'h20);
        issue_wr_i = 1'b0; rs_en_i = 2'b01; set_rd(5'd5, 5'd0);
        #1;
        chk("raw_dep_stall", 64'(issue_stall_o), 64'h1);
        chk("raw_dep_rs_busy", 64'(rs_busy_o), 64'h1);
        tick();
        wb_valid_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'hDEAD_BEEF;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("raw_wb_cycle_stall", 64'(issue_stall_o), 64'h0);
        chk("raw_wb_cycle_data", 64'(rdata(0)), 64'hDEAD_BEEF);
`else
        chk("raw_wb_cycle_stall", 64'(issue_stall_o), 64'h1);
        chk("raw_wb_cycle_data", 64'(rdata(0)), 64'h0);
`endif
        tick();
        wb_valid_i = 1'b0;
        #1;
        chk("raw_after_wb_stall", 64'(issue_stall_o), 64'h0);
        chk("raw_after_wb_data", 64'(rdata(0)), 64'hDEAD_BEEF);
        chk("raw_after_wb_busy", 64'(busy_vec_o), 64'h0);
        idle();
        tick();

        // WAW: second writer of x7 stalls; with forwarding a same-cycle wb lets it in.
        issue_valid_i = 1'b1; issue_wr_i = 1'b1; issue_rd_i = 5'd7;
        tick();
        chk("waw_busy_set", 64'(busy_vec_o), 64'h80);
        #1;
        chk("waw_stall", 64'(issue_stall_o), 64'h1);
        tick();
        wb_valid_i = 1'b1; wb_rd_i = 5'd7; wb_data_i = 32'h77;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("waw_wb_cycle_stall", 64'(issue_stall_o), 64'h0);
`else
        chk("waw_wb_cycle_stall", 64'(issue_stall_o), 64'h1);
`endif
        tick();
        idle();
`ifdef REGFILE_BYPASS_EN
        chk("waw_set_wins", 64'(busy_vec_o), 64'h80);
        wb_valid_i = 1'b1; wb_rd_i = 5'd7; wb_data_i = 32'h78;
        tick();
        idle();
`endif
        chk("waw_final_busy", 64'(busy_vec_o), 64'h0);
        chk("waw_no_err", 64'(wb_err_o), 64'h0);

        // Zero register: write dropped, never busy, no error.
        wb_valid_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'h1234;
        tick();
        idle();
        set_rd(5'd0, 5'd0);
        #1;
        chk("x0_rd0", 64'(rdata(0)), 64'h0);
        chk("x0_rd1", 64'(rdata(1)), 64'h0);
        chk("x0_busy", 64'(busy_vec_o), 64'h0);
        chk("x0_rs_busy", 64'(rs_busy_o), 64'h0);
        chk("x0_err", 64'(wb_err_o), 64'h0);

        // Table: reserve, write back, then read the target and another register.
        for (int i = 0; i < 6; i++) begin
            issue_valid_i = 1'b1; issue_wr_i = 1'b1; issue_rd_i = vecs[i].rd;
            tick();
            idle();
            wb_valid_i = 1'b1; wb_rd_i = vecs[i].rd; wb_data_i = vecs[i].data;
            tick();
            idle();
            set_rd(vecs[i].rd, vecs[i].addr1);
            #1;
            chk($sformatf("vec%0d_rd0", i), 64'(rdata(0)), 64'(vecs[i].exp0));
            chk($sformatf("vec%0d_rd1", i), 64'(rdata(1)), 64'(vecs[i].exp1));
            chk($sformatf("vec%0d_busy", i), 64'(busy_vec_o), 64'h0);
            chk($sformatf("vec%0d_rs_busy", i), 64'(rs_busy_o), 64'h0);
            chk($sformatf("vec%0d_err", i), 64'(wb_err_o), 64'h0);
        end

        // Protocol error: wb to unreserved x9 still writes and latches the flag.
        wb_valid_i = 1'b1; wb_rd_i = 5'd9; wb_data_i = 32'h99;
        tick();
        idle();
        chk("err_set", 64'(wb_err_o), 64'h1);
        set_rd(5'd9, 5'd0);
        #1;
        chk("err_reg_written", 64'(rdata(0)), 64'h99);
        tick();
        tick();
        chk("err_sticky", 64'(wb_err_o), 64'h1);

        // Asynchronous reset in flight, then a late writeback.
        issue_valid_i = 1'b1; issue_wr_i = 1'b1; issue_rd_i = 5'd3;
        tick();
        idle();
        chk("rst_pre_busy", 64'(busy_vec_o), 64'h8);
        #2;
        rst = 1'b0;
        set_rd(5'd9, 5'd3);
        #1;
        chk("rst_busy_cleared", 64'(busy_vec_o), 64'h0);
        chk("rst_err_cleared", 64'(wb_err_o), 64'h0);
        chk("rst_x9_zero", 64'(rdata(0)), 64'h0);
        chk("rst_x3_zero", 64'(rdata(1)), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        wb_valid_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'h33;
        tick();
        idle();
        chk("late_wb_err", 64'(wb_err_o), 64'h1);
        chk("late_wb_busy", 64'(busy_vec_o), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
